// File: rtl/game_pkg.sv
// Shared game definitions: state encoding, movement directions, screen and spawn geometry,
// and a saturating score adder.
package game_pkg;

  typedef enum logic [2:0] {
    WELCOME = 3'd0,
    START   = 3'd1,
    PLAY    = 3'd2,
    PAUSE   = 3'd3,
    FINISH  = 3'd4
  } game_state_t;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;
  localparam int unsigned SPAWN_X_L  = 64;
  localparam int unsigned SPAWN_X_R  = SCREEN_W - 64;
  localparam int unsigned SPAWN_Y_T  = 64;
  localparam int unsigned SPAWN_Y_B  = SCREEN_H - 64;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [7:0] b);
    logic [16:0] sum;
    sum = 17'(a) + 17'(b);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/sec_tick.sv
// Frame counter that wraps every PERIOD enabled frames; wrap_c flags the wrapping frame.
// Holds its count while disabled so a paused round resumes mid-second.
module sec_tick #(
  parameter int unsigned PERIOD = 60,
  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          wrap_c
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last   = (cnt_q == CW'(PERIOD - 1));
  assign wrap_c = en & last;
  assign cnt    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = last ? '0 : cnt_q + CW'(1);
  end

  always_ff @(negedge clk) begin
    if (!reset_active(rst_n)) cnt_q <= cnt_d;
    else                      cnt_q <= '0;
  end

  function automatic logic reset_active(input logic r_n);
    return ~r_n;
  endfunction

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: welcome/countdown/round/pause/finish flow, round timer and team score.
// Define GAME_FLOW_TIME_BONUS_EN to add BONUS_SEC round time per delivered order.
module game_flow_ctrl
  import game_pkg::*;
#(
`ifdef GAME_FLOW_TIME_BONUS_EN
  parameter int unsigned BONUS_SEC      = 5,
`endif
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned COUNTDOWN_SEC  = 3,
  parameter int unsigned ROUND_SEC      = 120
) (
  input  logic        vsync,
  input  logic        reset_n,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic        all_ready,
  input  logic [1:0]  num_players_sel,
  input  logic        order_done,
  input  logic [7:0]  order_pts,
  output logic [2:0]  game_state,
  output logic [1:0]  num_players,
  output logic        player_spawn,
  output logic [3:0]  countdown,
  output logic [7:0]  time_left,
  output logic [15:0] score
);

  localparam int unsigned FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  game_state_t state_q, state_d;
  logic [1:0]  np_q, np_d;
  logic        spawn_q, spawn_d;
  logic [3:0]  cd_q, cd_d;
  logic [7:0]  tl_q, tl_d;
  logic [15:0] score_q, score_d;
  logic        start_prev_q, pause_prev_q;

  logic            start_rise, pause_rise;
  logic            frame_last, bonus_now, expiry, pause_go;
  logic            tick_en, tick_clr, tick_wrap;
  logic [FC_W-1:0] frame_cnt;
`ifdef GAME_FLOW_TIME_BONUS_EN
  logic [8:0]      tl_sum;
`endif

  assign start_rise = start_btn & ~start_prev_q;
  assign pause_rise = pause_btn & ~pause_prev_q;
  assign frame_last = (frame_cnt == FC_W'(FRAMES_PER_SEC - 1));

`ifdef GAME_FLOW_TIME_BONUS_EN
  assign bonus_now = (state_q == PLAY) & order_done;
`else
  assign bonus_now = 1'b0;
`endif

  // A bonus on the last frame keeps the round alive; otherwise expiry beats a pause press.
  assign expiry   = (state_q == PLAY) & frame_last & (tl_q == 8'd1) & ~bonus_now;
  assign pause_go = (state_q == PLAY) & pause_rise & ~expiry;
  assign tick_en  = (state_q == START) | ((state_q == PLAY) & ~pause_go);
  assign tick_clr = (state_q == WELCOME) & start_rise & all_ready;

  sec_tick #(.PERIOD(FRAMES_PER_SEC)) u_sec_tick (
    .clk    (vsync),
    .rst_n  (reset_n),
    .en     (tick_en),
    .clr    (tick_clr),
    .cnt    (frame_cnt),
    .wrap_c (tick_wrap)
  );

  always_comb begin
    state_d = state_q;
    np_d    = np_q;
    cd_d    = cd_q;
    tl_d    = tl_q;
    score_d = score_q;
`ifdef GAME_FLOW_TIME_BONUS_EN
    tl_sum  = '0;
`endif
    unique case (state_q)
      WELCOME: begin
        np_d = num_players_sel;
        if (start_rise && all_ready) begin
          state_d = START;
          cd_d    = 4'(COUNTDOWN_SEC);
          score_d = '0;
        end
      end
      START: begin
        if (tick_wrap) begin
          if (cd_q == 4'd1) begin
            state_d = PLAY;
            cd_d    = '0;
            tl_d    = 8'(ROUND_SEC);
          end else begin
            cd_d = cd_q - 4'd1;
          end
        end
      end
      PLAY: begin
        if (order_done) score_d = sat_add16(score_q, order_pts);
        tl_d = tl_q - 8'(tick_wrap);
`ifdef GAME_FLOW_TIME_BONUS_EN
        if (order_done) begin
          tl_sum = 9'(tl_d) + 9'(BONUS_SEC);
          tl_d   = (tl_sum > 9'd255) ? 8'hFF : tl_sum[7:0];
        end
`endif
        if (expiry) begin
          state_d = FINISH;
          tl_d    = '0;
        end else if (pause_go) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (start_rise) begin
          state_d = WELCOME;
          tl_d    = '0;
        end else if (pause_rise) begin
          state_d = PLAY;
        end
      end
      FINISH: begin
        tl_d = '0;
        if (start_rise) state_d = WELCOME;
      end
      default: state_d = WELCOME;
    endcase
    spawn_d = (state_d == WELCOME) || (state_d == START);
  end

  always_ff @(negedge vsync) begin
    if (!reset_n) begin
      state_q      <= WELCOME;
      np_q         <= '0;
      spawn_q      <= 1'b1;
      cd_q         <= '0;
      tl_q         <= '0;
      score_q      <= '0;
      start_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      np_q         <= np_d;
      spawn_q      <= spawn_d;
      cd_q         <= cd_d;
      tl_q         <= tl_d;
      score_q      <= score_d;
      start_prev_q <= start_btn;
      pause_prev_q <= pause_btn;
    end
  end

  assign game_state   = state_q;
  assign num_players  = np_q;
  assign player_spawn = spawn_q;
  assign countdown    = cd_q;
  assign time_left    = tl_q;
  assign score        = score_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: two instances (3 s and 255 s rounds) share stimulus and are
// compared every frame against a rule-level reference model.
module tb_game_flow_ctrl;

  localparam int FPS    = 4;
  localparam int CD     = 2;
  localparam int ROUND0 = 3;
  localparam int ROUND1 = 255;
  localparam int BONUS  = 5;
`ifdef GAME_FLOW_TIME_BONUS_EN
  localparam bit BONUS_EN = 1'b1;
`else
  localparam bit BONUS_EN = 1'b0;
`endif

  logic        vsync;
  logic        reset_n, start_btn, pause_btn, all_ready, order_done;
  logic [1:0]  num_players_sel;
  logic [7:0]  order_pts;
  logic [2:0]  gs[2];
  logic [1:0]  np[2];
  logic        sp[2];
  logic [3:0]  cdn[2];
  logic [7:0]  tl[2];
  logic [15:0] sc[2];

  int n_checks, n_errors;

  int m_state[2], m_np[2], m_spawn[2], m_cd[2], m_tl[2], m_score[2], m_cnt[2];
  bit m_sp[2], m_pp[2];

  game_flow_ctrl #(.FRAMES_PER_SEC(FPS), .COUNTDOWN_SEC(CD), .ROUND_SEC(ROUND0)) dut0 (
    .vsync(vsync), .reset_n(reset_n), .start_btn(start_btn), .pause_btn(pause_btn),
    .all_ready(all_ready), .num_players_sel(num_players_sel), .order_done(order_done),
    .order_pts(order_pts), .game_state(gs[0]), .num_players(np[0]), .player_spawn(sp[0]),
    .countdown(cdn[0]), .time_left(tl[0]), .score(sc[0]));

  game_flow_ctrl #(.FRAMES_PER_SEC(FPS), .COUNTDOWN_SEC(CD), .ROUND_SEC(ROUND1)) dut1 (
    .vsync(vsync), .reset_n(reset_n), .start_btn(start_btn), .pause_btn(pause_btn),
    .all_ready(all_ready), .num_players_sel(num_players_sel), .order_done(order_done),
    .order_pts(order_pts), .game_state(gs[1]), .num_players(np[1]), .player_spawn(sp[1]),
    .countdown(cdn[1]), .time_left(tl[1]), .score(sc[1]));

  initial vsync = 1'b0;
  always #5 vsync = ~vsync;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    assert (obs === 32'(exp)) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: game rules applied frame by frame (state 0..4 = WELCOME..FINISH).
  task automatic model_step(input logic rst, st, pa, rdy, input logic [1:0] sel,
                            input logic od, input logic [7:0] pts);
    bit sr, pr, wrap, bon;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_state[i] = 0; m_np[i] = 0; m_cd[i] = 0; m_tl[i] = 0; m_score[i] = 0;
        m_cnt[i] = 0; m_sp[i] = 0; m_pp[i] = 0;
      end else begin
        sr = st && !m_sp[i];
        pr = pa && !m_pp[i];
        m_sp[i] = st;
        m_pp[i] = pa;
        case (m_state[i])
          0: begin
            m_np[i] = int'(sel);
            if (sr && rdy) begin
              m_state[i] = 1; m_cd[i] = CD; m_cnt[i] = 0; m_score[i] = 0;
            end
          end
          1: begin
            m_cnt[i]++;
            if (m_cnt[i] == FPS) begin
              m_cnt[i] = 0;
              if (m_cd[i] == 1) begin
                m_state[i] = 2; m_cd[i] = 0; m_tl[i] = (i == 0) ? ROUND0 : ROUND1;
              end else m_cd[i]--;
            end
          end
          2: begin
            if (od) m_score[i] = (m_score[i] + int'(pts) > 65535) ? 65535 : m_score[i] + int'(pts);
            bon  = BONUS_EN && od;
            wrap = (m_cnt[i] == FPS - 1);
            if (wrap && m_tl[i] == 1 && !bon) begin
              m_state[i] = 4; m_tl[i] = 0; m_cnt[i] = 0;
            end else begin
              if (!pr) begin
                m_cnt[i]++;
                if (m_cnt[i] == FPS) begin m_cnt[i] = 0; m_tl[i]--; end
              end
              if (bon) m_tl[i] = (m_tl[i] + BONUS > 255) ? 255 : m_tl[i] + BONUS;
              if (pr) m_state[i] = 3;
            end
          end
          3: begin
            if (sr) begin m_state[i] = 0; m_tl[i] = 0; end
            else if (pr) m_state[i] = 2;
          end
          default: begin
            m_tl[i] = 0;
            if (sr) m_state[i] = 0;
          end
        endcase
      end
      m_spawn[i] = (m_state[i] <= 1) ? 1 : 0;
    end
  endtask

  task automatic check_dut(input int i, input string tag);
    chk($sformatf("%s.d%0d.state", tag, i), 32'(gs[i]), m_state[i]);
    chk($sformatf("%s.d%0d.nplayers", tag, i), 32'(np[i]), m_np[i]);
    chk($sformatf("%s.d%0d.spawn", tag, i), 32'(sp[i]), m_spawn[i]);
    chk($sformatf("%s.d%0d.countdown", tag, i), 32'(cdn[i]), m_cd[i]);
    chk($sformatf("%s.d%0d.time_left", tag, i), 32'(tl[i]), m_tl[i]);
    chk($sformatf("%s.d%0d.score", tag, i), 32'(sc[i]), m_score[i]);
  endtask

  // One frame: drive inputs, advance the model, let the DUT update on falling vsync, compare.
  task automatic step(input logic rst, st, pa, rdy, input logic [1:0] sel,
                      input logic od, input logic [7:0] pts, input string tag);
    reset_n = ~rst; start_btn = st; pause_btn = pa; all_ready = rdy;
    num_players_sel = sel; order_done = od; order_pts = pts;
    model_step(rst, st, pa, rdy, sel, od, pts);
    @(negedge vsync);
    @(posedge vsync);
    check_dut(0, tag);
    check_dut(1, tag);
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 8'd0, tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    step(1, 0, 0, 0, 2'd0, 0, 8'd0, "reset");
    chk("reset.state", 32'(gs[0]), 0);
    chk("reset.spawn", 32'(sp[0]), 1);
    chk("reset.score", 32'(sc[0]), 0);
    chk("reset.time_left", 32'(tl[0]), 0);

    step(0, 1, 0, 1, 2'd2, 0, 8'd0, "start");
    chk("start.state", 32'(gs[0]), 1);
    chk("start.nplayers", 32'(np[0]), 2);
    chk("start.countdown", 32'(cdn[0]), 2);
    idle(4, "cd");
    chk("cd.countdown1", 32'(cdn[0]), 1);
    idle(4, "cd");
    chk("play.state", 32'(gs[0]), 2);
    chk("play.time_left", 32'(tl[0]), 3);
    chk("play.spawn", 32'(sp[0]), 0);
    chk("play.time_left_long", 32'(tl[1]), 255);

    repeat (3) step(0, 0, 0, 1, 2'd2, 1, 8'd200, "orders");
    chk("orders.score0", 32'(sc[0]), 600);
    chk("orders.score1", 32'(sc[1]), 600);
    repeat (260) step(0, 0, 0, 1, 2'd2, 1, 8'd255, "saturate");
    chk("saturate.score", 32'(sc[1]), 16'hFFFF);

    step(1, 1, 0, 1, 2'd2, 0, 8'd0, "midreset");
    chk("midreset.state", 32'(gs[1]), 0);
    chk("midreset.score", 32'(sc[1]), 0);
    idle(1, "idle");

    step(0, 1, 0, 1, 2'd2, 0, 8'd0, "start2");
    idle(8, "cd2");
    idle(5, "run");
    chk("prepause.time_left", 32'(tl[0]), 2);
    step(0, 0, 1, 1, 2'd2, 0, 8'd0, "pause");
    chk("pause.state", 32'(gs[0]), 3);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 1, 2'd2, 1'(k % 2), 8'd50, "frozen");
    chk("frozen.state", 32'(gs[0]), 3);
    chk("frozen.time_left", 32'(tl[0]), 2);
    chk("frozen.score", 32'(sc[0]), 0);
    step(0, 0, 1, 1, 2'd2, 0, 8'd0, "resume");
    chk("resume.state", 32'(gs[0]), 2);
    idle(6, "tail");
    chk("tail.state", 32'(gs[0]), 2);
    chk("tail.time_left", 32'(tl[0]), 1);
    idle(1, "expire");
    chk("expire.state", 32'(gs[0]), 4);
    chk("expire.time_left", 32'(tl[0]), 0);

    step(0, 0, 1, 1, 2'd2, 0, 8'd0, "pause1");
    chk("pause1.state", 32'(gs[1]), 3);
    idle(1, "idle");
    step(0, 1, 1, 1, 2'd2, 0, 8'd0, "abort");
    chk("abort.state1", 32'(gs[1]), 0);
    chk("abort.time_left1", 32'(tl[1]), 0);
    chk("abort.state0", 32'(gs[0]), 0);

    idle(1, "idle");
    step(0, 1, 0, 0, 2'd2, 0, 8'd0, "notready");
    chk("notready.state", 32'(gs[0]), 0);
    idle(1, "idle");
    step(0, 1, 0, 1, 2'd2, 0, 8'd0, "held");
    chk("held.state", 32'(gs[0]), 1);
    repeat (9) step(0, 1, 0, 1, 2'd2, 0, 8'd0, "held");
    chk("held.state_end", 32'(gs[0]), 2);
    chk("held.time_left", 32'(tl[0]), 3);

    idle(10, "run2");
    chk("run2.time_left", 32'(tl[0]), 1);
    step(0, 0, 1, 1, 2'd2, 0, 8'd0, "pause_on_expiry");
    chk("pause_on_expiry.state", 32'(gs[0]), 4);
    chk("pause_on_expiry.time_left", 32'(tl[0]), 0);

    idle(1, "idle");
    step(0, 1, 0, 1, 2'd2, 0, 8'd0, "back");
    idle(1, "idle");
    step(0, 1, 0, 1, 2'd2, 0, 8'd0, "start3");
    idle(8, "cd3");
    idle(11, "run3");
    step(0, 0, 0, 1, 2'd2, 1, 8'd10, "wrap_order");
`ifdef GAME_FLOW_TIME_BONUS_EN
    chk("wrap_order.state", 32'(gs[0]), 2);
    chk("wrap_order.time_left", 32'(tl[0]), 5);
`else
    chk("wrap_order.state", 32'(gs[0]), 4);
    chk("wrap_order.time_left", 32'(tl[0]), 0);
`endif
    chk("wrap_order.score", 32'(sc[0]), 10);

    for (int k = 0; k < 800; k++) begin
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) != 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
           8'($urandom_range(0, 255)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
